// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Multiplexed 4-digit BCD display scanner with a timed message overlay.
//   A refresh divider produces a one-cycle tick every DIV clocks. Each tick
//   advances the digit index. A two-state FSM overlays msg_value for
//   HOLD_TICKS ticks. The displayed source only changes at a frame boundary,
//   so a frame is never split between the two sources.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   BASE  | no overlay pending; bal_value is the requested source
//   MSG   | overlay active; hold_cnt counts the remaining ticks
//
// Ports
//   clk          system clock; all state updates on its rising edge
//   reset        asynchronous, active-high reset
//   bal_value    base source, four BCD digits, [3:0] is the rightmost digit
//   msg_req      single-cycle request to latch and show msg_value
//   msg_value    overlay source, sampled only when msg_req is 1
//   blank_lz     enables leading-zero blanking of the base source
//   tick         one-cycle scan-advance pulse
//   s            current digit index
//   an           active-low anode enables
//   digit        BCD value of the current digit
//   digit_blank  1 while the current slot is blanked
//   msg_busy     1 while the overlay FSM is in MSG
module display_scan_ctrl #(
    parameter int DIV        = 100000,
    parameter int HOLD_TICKS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bal_value,
    input  logic        msg_req,
    input  logic [15:0] msg_value,
    input  logic        blank_lz,
    output logic        tick,
    output logic [1:0]  s,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        digit_blank,
    output logic        msg_busy
);

    localparam int DW = $clog2(DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    typedef enum logic {
        BASE = 1'b0,
        MSG  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    state_t        src_sel;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [15:0]   msg_reg, msg_nxt;
    logic [15:0]   src;
    logic [3:1]    upper_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s <= 2'd0;
        else if (tick)
            s <= s + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BASE;
            hold_cnt <= '0;
            msg_reg  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            msg_reg  <= msg_nxt;
        end
    end

    // The source follows the FSM only on the tick that wraps s from 3 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            src_sel <= BASE;
        else if (tick && (s == 2'd3))
            src_sel <= state;
    end

    // A request always wins over a simultaneous tick or terminal-count exit.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        msg_nxt   = msg_reg;
        case (state)
            BASE: begin
                if (msg_req) begin
                    state_nxt = MSG;
                    hold_nxt  = HOLD_LOAD;
                    msg_nxt   = msg_value;
                end
            end
            MSG: begin
                if (msg_req) begin
                    hold_nxt = HOLD_LOAD;
                    msg_nxt  = msg_value;
                end else if (tick) begin
                    hold_nxt = hold_cnt - HW'(1);
                    if (hold_cnt == HW'(1))
                        state_nxt = BASE;
                end
            end
            default: state_nxt = BASE;
        endcase
    end

    assign msg_busy = (state == MSG);

    // Display decode
    assign src = (src_sel == MSG) ? msg_reg : bal_value;

    // upper_zero[i]: every base digit from position i up to 3 is zero.
    assign upper_zero[3] = (bal_value[15:12] == 4'd0);
    assign upper_zero[2] = (bal_value[15:8]  == 8'd0);
    assign upper_zero[1] = (bal_value[15:4]  == 12'd0);

    always_comb begin
        digit       = src[3:0];
        digit_blank = 1'b0;
        case (s)
            2'd0: digit = src[3:0];
            2'd1: begin
                digit       = src[7:4];
                digit_blank = upper_zero[1];
            end
            2'd2: begin
                digit       = src[11:8];
                digit_blank = upper_zero[2];
            end
            2'd3: begin
                digit       = src[15:12];
                digit_blank = upper_zero[3];
            end
            default: digit = src[3:0];
        endcase
        if (!blank_lz || (src_sel != BASE))
            digit_blank = 1'b0;
    end

    assign an = digit_blank ? 4'b1111 : ~(4'b0001 << s);

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int DIV  = 4;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bal_value = 16'h0000;
    logic        msg_req = 1'b0;
    logic [15:0] msg_value = 16'h0000;
    logic        blank_lz = 1'b0;
    logic        tick;
    logic [1:0]  s;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        digit_blank;
    logic        msg_busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: k = clock edges since reset release; tick and s
    // follow from k arithmetically; the overlay is tracked as events.
    int          k;
    bit          m_busy;
    bit          m_shown;
    int          m_rem;
    logic [15:0] m_msg;

    display_scan_ctrl #(.DIV(DIV), .HOLD_TICKS(HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .bal_value   (bal_value),
        .msg_req     (msg_req),
        .msg_value   (msg_value),
        .blank_lz    (blank_lz),
        .tick        (tick),
        .s           (s),
        .an          (an),
        .digit       (digit),
        .digit_blank (digit_blank),
        .msg_busy    (msg_busy)
    );

    always #5 clk = ~clk;

    function automatic bit m_tick();
        return (k >= DIV) && (k % DIV == 0);
    endfunction

    function automatic int m_s();
        return (k >= 1) ? ((k - 1) / DIV) % 4 : 0;
    endfunction

    task automatic model_reset();
        k       = 0;
        m_busy  = 1'b0;
        m_shown = 1'b0;
        m_rem   = 0;
        m_msg   = 16'h0000;
    endtask

    task automatic check();
        int          sm;
        logic [15:0] src;
        logic [15:0] upper;
        logic [3:0]  e_digit;
        logic        e_blank;
        logic [3:0]  e_an;
        logic        e_tick;
        sm      = m_s();
        e_tick  = m_tick();
        src     = m_shown ? m_msg : bal_value;
        e_digit = 4'(src >> (4 * sm));
        upper   = bal_value >> (4 * sm);
        e_blank = blank_lz && !m_shown && (sm != 0) && (upper == 16'h0000);
        e_an    = e_blank ? 4'hF : (4'hF & ~(4'b0001 << sm));
        vectors++;
        assert (tick === e_tick) else begin
            miscompares++;
            $error("FAIL tick k=%0d: got %b want %b", k, tick, e_tick);
        end
        assert (s === 2'(sm)) else begin
            miscompares++;
            $error("FAIL s k=%0d: got %0d want %0d", k, s, sm);
        end
        assert (an === e_an) else begin
            miscompares++;
            $error("FAIL an k=%0d: got %b want %b", k, an, e_an);
        end
        assert (digit === e_digit) else begin
            miscompares++;
            $error("FAIL digit k=%0d: got %h want %h", k, digit, e_digit);
        end
        assert (digit_blank === e_blank) else begin
            miscompares++;
            $error("FAIL digit_blank k=%0d: got %b want %b", k, digit_blank, e_blank);
        end
        assert (msg_busy === m_busy) else begin
            miscompares++;
            $error("FAIL msg_busy k=%0d: got %b want %b", k, msg_busy, m_busy);
        end
    endtask

    task automatic step();
        bit t_b;
        int s_b;
        bit busy_b;
        t_b    = m_tick();
        s_b    = m_s();
        busy_b = m_busy;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (msg_req) begin
                m_busy = 1'b1;
                m_rem  = HOLD;
                m_msg  = msg_value;
            end else if (m_busy && t_b) begin
                m_rem--;
                if (m_rem == 0)
                    m_busy = 1'b0;
            end
            if (t_b && s_b == 3)
                m_shown = busy_b;
            k++;
        end
        #1;
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic pulse(input logic [15:0] v);
        msg_req   = 1'b1;
        msg_value = v;
        step();
        msg_req   = 1'b0;
        msg_value = 16'($urandom);
    endtask

    task automatic wait_s(input int target, input string tag);
        for (int i = 0; i < 64 && m_s() != target; i++)
            step();
        vectors++;
        assert (m_s() == target) else begin
            miscompares++;
            $error("FAIL %s: timeout, s=%0d want %0d", tag, m_s(), target);
        end
    endtask

    initial begin
        int lz;
        bit found;
        model_reset();
        bal_value = 16'h9876;
        #1;
        check();
        run(3);

        // Free-running scan with all digits lit
        reset = 1'b0;
        run(32);

        // Leading-zero blanking on and off
        bal_value = 16'h0042;
        blank_lz  = 1'b1;
        run(16);
        blank_lz  = 1'b0;
        run(16);

        // Overlay request while s is 1, held until the base returns
        bal_value = 16'h0507;
        blank_lz  = 1'b1;
        wait_s(1, "wait_s1_overlay");
        pulse(16'h1234);
        run(72);

        // Retrigger on the terminal tick
        pulse(16'h1111);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_busy && m_rem == 1 && m_tick())
                found = 1'b1;
            else
                step();
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL wait_terminal_tick: timeout, busy=%b rem=%0d", m_busy, m_rem);
        end
        pulse(16'h5678);
        vectors++;
        assert (int'(dut.hold_cnt) == HOLD) else begin
            miscompares++;
            $error("FAIL hold_reload: got %0d want %0d", dut.hold_cnt, HOLD);
        end
        run(72);

        // Randomized traffic with leading-zero-heavy base values
        for (int i = 0; i < 600; i++) begin
            lz        = $urandom_range(0, 4);
            bal_value = 16'($urandom >> (4 * lz + 16));
            if ($urandom_range(0, 7) == 0)
                blank_lz = ~blank_lz;
            if ($urandom_range(0, 39) == 0)
                pulse(16'($urandom));
            else
                step();
        end

        // Asynchronous reset in the middle of an overlay with s at 2
        bal_value = 16'h0310;
        blank_lz  = 1'b0;
        wait_s(1, "wait_s1_reset");
        pulse(16'h4321);
        wait_s(2, "wait_s2_reset");
        vectors++;
        assert (m_busy) else begin
            miscompares++;
            $error("FAIL busy_before_reset: model overlay ended early");
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check();
        run(2);
        reset = 1'b0;
        run(24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
